alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter reg_width, default 12, datapath width in bits.
REQ-002 SHALL have port clk  input  1  system clock, rising edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  operation request from control unit, sampled at rising clk.
REQ-005 SHALL have port op  input  4  opcode, sampled with start.
REQ-006 SHALL have port a  input  reg_width  operand A, from accumulator ALU output.
REQ-007 SHALL have port b  input  reg_width  operand B, from bus.
REQ-008 SHALL have port result  output  reg_width  registered result, drives accumulator AC_in.
REQ-009 SHALL have port ac_we  output  1  one-cycle write strobe, drives accumulator write_en.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 SHALL have port carry  output  1  carry/borrow/overflow flag, registered with result.
REQ-012 SHALL have port div_err  output  1  divide-by-zero flag, registered with result.

Function
REQ-013 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN; reset state IDLE.
REQ-014 SHALL latch a, b, op only when start=1 in IDLE; start while busy=1 ignored, no queuing.
REQ-015 Single-cycle ops (ADD, SUB, AND, OR, XOR, INC, DEC, PASSB) SHALL update result/carry and pulse ac_we at the edge that samples start; FSM stays IDLE.
REQ-016 ADD: result = (a+b) mod 2^reg_width, carry = bit reg_width of sum; SUB: result = (a-b) mod 2^reg_width, carry = 1 iff a<b (unsigned).
REQ-017 INC/DEC: a+1 / a-1 with wrap; carry = 1 on wrap (0xFFF->0 / 0->0xFFF for width 12).
REQ-018 Logic ops and PASSB SHALL clear carry.
REQ-019 MUL: unsigned shift-add, one bit per cycle; FSM IDLE->MUL_RUN, busy=1 for exactly reg_width cycles, then result = low reg_width bits of product, carry = 1 iff high half nonzero, ac_we pulsed, FSM->IDLE; start-to-ac_we latency reg_width+1 edges.
REQ-020 DIV: unsigned restoring, one quotient bit per cycle, same timing as MUL; result = quotient, carry = 0.
REQ-021 DIV with b=0 SHALL complete in one edge: result = all ones, div_err=1, ac_we pulsed, no DIV_RUN entry.
REQ-022 div_err SHALL be cleared by any other completed operation.
REQ-023 Undefined opcodes SHALL be NOP: no ac_we, result/flags unchanged, FSM stays IDLE.
REQ-024 ac_we SHALL never be high two consecutive cycles for one start; busy=0 in the ac_we cycle.
REQ-025 result, carry, div_err SHALL hold value between operations.

Reset
REQ-026 reset SHALL asynchronously force result=0, carry=0, div_err=0, ac_we=0, busy=0, FSM=IDLE, iteration counter=0.
REQ-027 reset asserted mid MUL/DIV SHALL abort the operation with no ac_we pulse after release.

Configuration
REQ-028 Macro ALU_SEQ_DIV_EN SHALL compile in the divider and DIV_RUN state.
REQ-029 Without ALU_SEQ_DIV_EN, DIV opcode SHALL behave as NOP (REQ-023) and div_err SHALL be tied 0.

Structure
REQ-030 Shared package SHALL hold opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, INC=5, DEC=6, PASSB=7, MUL=8, DIV=9) and FSM state encoding.
REQ-031 Iterative datapath SHALL be one sub-module, alu_seq_iter (shift-add/restoring core, counter, done), controlled by the top FSM.

Verification
REQ-032 ADD a=0xFFF b=0x001 -> result=0x000, carry=1, ac_we one cycle at sampling edge.
REQ-033 MUL a=0x040 b=0x040 -> busy 12 cycles, result=0x000, carry=1, ac_we at edge 13; a=3 b=5 -> result=0x00F, carry=0.
REQ-034 DIV a=100 b=7 (ALU_SEQ_DIV_EN) -> result=14 after 13 edges; b=0 -> result=0xFFF, div_err=1 next edge; without macro -> no ac_we.
REQ-035 start pulsed during MUL busy with op=ADD -> ignored, only MUL result delivered.
REQ-036 reset asserted at MUL cycle 5 -> all outputs 0 immediately, no ac_we after release; next ADD 2+3 -> result=5.
REQ-037 op=0xF with start -> no ac_we, result unchanged.

Source files
------------

// File: rtl/alu_seq_unit_pkg.sv
// Shared opcodes and FSM state encoding for alu_seq_unit.
// Define ALU_SEQ_DIV_EN to build the divider and its DIV_RUN state.
package alu_seq_unit_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpInc  = 4'd5;
  localparam logic [3:0] OpDec  = 4'd6;
  localparam logic [3:0] OpPassB = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;
  localparam logic [3:0] OpDiv  = 4'd9;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
`ifdef ALU_SEQ_DIV_EN
    StDivRun = 2'd2,
`endif
    StMulRun = 2'd1
  } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider core, one bit per step.
// The divider path exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div_i,
`endif
  input  logic             step_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o,
  output logic             last_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  // hi holds the partial product high half / remainder, lo the multiplier / quotient.
  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width:0]   add_sum;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic [Width:0]   shifted;
  logic [Width-1:0] trial;
  logic             fits;
`endif

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
`ifdef ALU_SEQ_DIV_EN
    div_d   = div_q;
    shifted = {hi_q, lo_q[Width-1]};
    fits    = shifted >= {1'b0, mcand_q};
    trial   = shifted[Width-1:0] - mcand_q;
`endif
    if (load_i) begin
      hi_d    = '0;
      cnt_d   = '0;
      lo_d    = b_i;
      mcand_d = a_i;
`ifdef ALU_SEQ_DIV_EN
      div_d   = div_i;
      if (div_i) begin
        lo_d    = a_i;
        mcand_d = b_i;
      end
`endif
    end else if (step_i) begin
      cnt_d = cnt_q + CntW'(1);
      hi_d  = add_sum[Width:1];
      lo_d  = {add_sum[0], lo_q[Width-1:1]};
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
        hi_d = fits ? trial : shifted[Width-1:0];
        lo_d = {lo_q[Width-2:0], fits};
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
      div_q   <= div_d;
`endif
    end
  end

  // Next-state values let the controller capture the final step in the same edge.
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;
  assign last_o = (cnt_q == CntW'(Width - 1));

endmodule

// File: rtl/alu_seq_unit.sv
// Sequencing ALU: single-cycle logic/arith ops plus iterative MUL and optional DIV.
// Define ALU_SEQ_DIV_EN to enable DIV; otherwise DIV is a NOP and div_err stays 0.
module alu_seq_unit
  import alu_seq_unit_pkg::*;
#(
  parameter int unsigned reg_width = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [reg_width-1:0] a,
  input  logic [reg_width-1:0] b,
  output logic [reg_width-1:0] result,
  output logic                 ac_we,
  output logic                 busy,
  output logic                 carry,
  output logic                 div_err
);

  localparam logic [reg_width-1:0] OneW = reg_width'(1);

  state_e               state_q, state_d;
  logic [reg_width-1:0] result_q, result_d;
  logic                 carry_q, carry_d, div_err_q, div_err_d;
  logic                 ac_we_q, ac_we_d, busy_q, busy_d;
  logic                 iter_load, iter_step, iter_last;
  logic [reg_width-1:0] iter_hi, iter_lo;

  alu_seq_iter #(
    .Width (reg_width)
  ) u_iter (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (iter_load),
`ifdef ALU_SEQ_DIV_EN
    .div_i  (op == OpDiv),
`endif
    .step_i (iter_step),
    .a_i    (a),
    .b_i    (b),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo),
    .last_o (iter_last)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    carry_d   = carry_q;
    div_err_d = div_err_q;
    ac_we_d   = 1'b0;
    busy_d    = busy_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ac_we_d   = 1'b1;
          div_err_d = 1'b0;
          carry_d   = 1'b0;
          case (op)
            OpAdd:   {carry_d, result_d} = {1'b0, a} + {1'b0, b};
            OpSub: begin
              result_d = a - b;
              carry_d  = a < b;
            end
            OpAnd:   result_d = a & b;
            OpOr:    result_d = a | b;
            OpXor:   result_d = a ^ b;
            OpInc: begin
              result_d = a + OneW;
              carry_d  = &a;
            end
            OpDec: begin
              result_d = a - OneW;
              carry_d  = ~|a;
            end
            OpPassB: result_d = b;
            OpMul: begin
              ac_we_d   = 1'b0;
              carry_d   = carry_q;
              div_err_d = div_err_q;
              iter_load = 1'b1;
              busy_d    = 1'b1;
              state_d   = StMulRun;
            end
`ifdef ALU_SEQ_DIV_EN
            OpDiv: begin
              if (b == '0) begin
                result_d  = '1;
                div_err_d = 1'b1;
              end else begin
                ac_we_d   = 1'b0;
                carry_d   = carry_q;
                div_err_d = div_err_q;
                iter_load = 1'b1;
                busy_d    = 1'b1;
                state_d   = StDivRun;
              end
            end
`endif
            default: begin
              // Undefined opcode: leave every architectural output untouched.
              ac_we_d   = 1'b0;
              carry_d   = carry_q;
              div_err_d = div_err_q;
            end
          endcase
        end
      end
      StMulRun: begin
        iter_step = 1'b1;
        if (iter_last) begin
          result_d  = iter_lo;
          carry_d   = |iter_hi;
          div_err_d = 1'b0;
          ac_we_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      StDivRun: begin
        iter_step = 1'b1;
        if (iter_last) begin
          result_d  = iter_lo;
          carry_d   = 1'b0;
          div_err_d = 1'b0;
          ac_we_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      carry_q   <= 1'b0;
      div_err_q <= 1'b0;
      ac_we_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      div_err_q <= div_err_d;
      ac_we_q   <= ac_we_d;
      busy_q    <= busy_d;
    end
  end

  assign result  = result_q;
  assign carry   = carry_q;
  assign div_err = div_err_q;
  assign ac_we   = ac_we_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit; DIV vectors follow ALU_SEQ_DIV_EN.
module tb_alu_seq_unit;
  import alu_seq_unit_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         ac_we, busy, carry, div_err;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         e;
    int           at_edge;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt = 0;
  logic [W-1:0] last_r = '0;

  alu_seq_unit #(
    .reg_width (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .ac_we   (ac_we),
    .busy    (busy),
    .carry   (carry),
    .div_err (div_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (ac_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ac_we actual=write result=%0h expected=no write", result);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_result", int'(result), int'(mon_e.r));
        chk("wb_carry", int'(carry), int'(mon_e.c));
        chk("wb_div_err", int'(div_err), int'(mon_e.e));
        chk("wb_edge", edge_cnt, mon_e.at_edge);
        chk("wb_busy_low", int'(busy), 0);
      end
    end
  end

  task automatic run(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input bit exp_we, input logic [W-1:0] r, input bit c, input bit e,
                     input int lat);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = aa; b = bb;
    if (exp_we) begin
      sb.push_back('{r, c, e, edge_cnt + lat});
      last_r = r;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (lat > 1) begin
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      chk("busy_cycles", n, W);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_div_err", int'(div_err), 0);
    chk("rst_ac_we", int'(ac_we), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    run(OpAdd,   12'hFFF, 12'h001, 1, 12'h000, 1, 0, 1);
    run(OpAdd,   12'h123, 12'h456, 1, 12'h579, 0, 0, 1);
    run(OpSub,   12'h005, 12'h007, 1, 12'hFFE, 1, 0, 1);
    run(OpSub,   12'h800, 12'h001, 1, 12'h7FF, 0, 0, 1);
    run(OpAnd,   12'hF0F, 12'h0FF, 1, 12'h00F, 0, 0, 1);
    run(OpOr,    12'hF00, 12'h00F, 1, 12'hF0F, 0, 0, 1);
    run(OpXor,   12'hAAA, 12'hFFF, 1, 12'h555, 0, 0, 1);
    run(OpInc,   12'hFFF, 12'h000, 1, 12'h000, 1, 0, 1);
    run(OpInc,   12'h010, 12'h000, 1, 12'h011, 0, 0, 1);
    run(OpDec,   12'h000, 12'h000, 1, 12'hFFF, 1, 0, 1);
    run(OpDec,   12'h010, 12'h000, 1, 12'h00F, 0, 0, 1);
    run(OpPassB, 12'h123, 12'hABC, 1, 12'hABC, 0, 0, 1);
    run(OpMul,   12'h040, 12'h040, 1, 12'h000, 1, 0, W + 1);
    run(OpMul,   12'h003, 12'h005, 1, 12'h00F, 0, 0, W + 1);
    run(OpMul,   12'hFFF, 12'hFFF, 1, 12'h001, 1, 0, W + 1);

`ifdef ALU_SEQ_DIV_EN
    run(OpDiv,   12'd100, 12'd7,   1, 12'd14,  0, 0, W + 1);
    run(OpDiv,   12'h123, 12'h000, 1, 12'hFFF, 0, 1, 1);
    run(OpAdd,   12'h001, 12'h001, 1, 12'h002, 0, 0, 1);
`else
    run(OpDiv,   12'd100, 12'd7,   0, 12'h000, 0, 0, 1);
    chk("div_disabled_result", int'(result), int'(last_r));
    chk("div_disabled_busy", int'(busy), 0);
    chk("div_disabled_err", int'(div_err), 0);
`endif

    // Undefined opcode leaves result alone.
    run(4'hF, 12'h111, 12'h222, 0, 12'h000, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("nop_result", int'(result), int'(last_r));

    // ADD pulsed mid-MUL must be dropped.
    @(posedge clk); #1;
    start = 1'b1; op = OpMul; a = 12'h0AB; b = 12'h010;
    sb.push_back('{12'hAB0, 1'b0, 1'b0, edge_cnt + W + 1});
    last_r = 12'hAB0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = OpAdd; a = 12'h002; b = 12'h003;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ignore_busy_ended", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_result", int'(result), 12'hAB0);

    // Reset in the middle of a MUL aborts it silently.
    @(posedge clk); #1;
    start = 1'b1; op = OpMul; a = 12'h003; b = 12'h005;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_abort_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_result", int'(result), 0);
    chk("abort_carry", int'(carry), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ac_we", int'(ac_we), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    run(OpAdd, 12'h002, 12'h003, 1, 12'h005, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
